// File: rtl/fifo_rptr_empty.sv
// fifo_rptr_empty: read-domain pointer, Gray export and empty/level status of the async FIFO.
// Define RPTR_UNDERFLOW_ERR_EN to build the sticky underflow flag on rerr.
module fifo_rptr_empty #(
  parameter int ADDR      = 4,
  parameter int AE_THRESH = 2
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic            rinc,
  input  logic [ADDR:0]   rq2_wptr_bin,
  output logic [ADDR-1:0] raddr,
  output logic [ADDR:0]   rptr_gray,
  output logic            rpop,
  output logic            rempty,
  output logic            ralmost_empty,
  output logic [ADDR:0]   rlevel,
  output logic            rerr
);
  localparam logic [ADDR:0] AE = AE_THRESH[ADDR:0];
  logic [ADDR:0] rbin, rbin_next, level_next;
  assign rpop       = rinc & ~rempty;
  assign rbin_next  = rbin + {{ADDR{1'b0}}, rpop};
  assign level_next = rq2_wptr_bin - rbin_next;
  assign raddr      = rbin[ADDR-1:0];
  // status is computed from the post-pop pointer so the last pop raises empty at its own edge
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin          <= '0;
      rptr_gray     <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin          <= rbin_next;
      rptr_gray     <= rbin_next ^ (rbin_next >> 1);
      rempty        <= rbin_next == rq2_wptr_bin;
      ralmost_empty <= level_next <= AE;
      rlevel        <= level_next;
    end
  end
`ifdef RPTR_UNDERFLOW_ERR_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rerr <= 1'b0;
    else if (rinc & rempty) rerr <= 1'b1;
  end
`else
  assign rerr = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rptr_empty.sv
// tb_fifo_rptr_empty: directed scoreboard bench for fifo_rptr_empty (ADDR=4, AE_THRESH=2).
module tb_fifo_rptr_empty;
  logic       rclk = 1'b0;
  logic       rrst_n = 1'b1;
  logic       rinc = 1'b0;
  logic [4:0] wptr = '0;
  logic [3:0] raddr;
  logic [4:0] rptr_gray, rlevel;
  logic       rpop, rempty, ralmost_empty, rerr;
  int checks = 0;
  int errors = 0;

  fifo_rptr_empty #(.ADDR(4), .AE_THRESH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr_bin(wptr),
    .raddr(raddr), .rptr_gray(rptr_gray), .rpop(rpop), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel), .rerr(rerr)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [3:0] raddr;
    logic [4:0] gray, level, prev;
    logic       empty, ae, err, rpop, popped;
  } exp_t;
  exp_t q[$];

  logic [4:0] mbin = '0, mlevel = '0;
  logic       mempty = 1'b1, mae = 1'b1, merr = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbin = '0; mlevel = '0; mempty = 1'b1; mae = 1'b1; merr = 1'b0;
  endtask

  // Drive one cycle of stimulus and push the state expected after the next rising edge.
  task automatic step(input logic ri, input logic [4:0] w);
    exp_t e;
    logic p;
    @(negedge rclk); #1;
    rinc = ri; wptr = w;
    p = ri && !mempty;
`ifdef RPTR_UNDERFLOW_ERR_EN
    if (ri && mempty) merr = 1'b1;
`endif
    e.prev   = mbin ^ (mbin >> 1);
    mbin     = mbin + {4'b0, p};
    mlevel   = w - mbin;
    mempty   = (mlevel == 0);
    mae      = (mlevel <= 2);
    e.raddr  = mbin[3:0];
    e.gray   = mbin ^ (mbin >> 1);
    e.level  = mlevel;
    e.empty  = mempty;
    e.ae     = mae;
    e.err    = merr;
    e.rpop   = ri && !mempty;
    e.popped = p;
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge rclk); #3;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rempty"}, rempty, 1);
    chk({tag, "_ralmost_empty"}, ralmost_empty, 1);
    chk({tag, "_rlevel"}, rlevel, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_rptr_gray"}, rptr_gray, 0);
    chk({tag, "_rerr"}, rerr, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge rclk); #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("raddr", raddr, e.raddr);
        chk("rptr_gray", rptr_gray, e.gray);
        chk("rlevel", rlevel, e.level);
        chk("rempty", rempty, e.empty);
        chk("ralmost_empty", ralmost_empty, e.ae);
        chk("rerr", rerr, e.err);
        chk("rpop", rpop, e.rpop);
        chk("gray_step", $countones(rptr_gray ^ e.prev), e.popped);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    #2 rrst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge rclk); @(negedge rclk); #1 rrst_n = 1'b1;
    model_reset();
    // three entries, four requests
    step(1'b0, 5'd3);
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3);
    settle();
    chk("three_pop_raddr", raddr, 3);
    chk("three_pop_gray", rptr_gray, 5'b00010);
    chk("three_pop_rempty", rempty, 1);
`ifdef RPTR_UNDERFLOW_ERR_EN
    chk("underflow_rerr", rerr, 1);
`else
    chk("underflow_rerr", rerr, 0);
`endif
    // full FIFO from a fresh pointer
    @(negedge rclk); #1 rrst_n = 1'b0; rinc = 1'b0;
    model_reset();
    #2 rrst_n = 1'b1;
    step(1'b0, 5'd16);
    settle();
    chk("full_rlevel", rlevel, 16);
    chk("full_rempty", rempty, 0);
    chk("full_ralmost_empty", ralmost_empty, 0);
    for (int i = 0; i < 14; i++) step(1'b1, 5'd16);
    settle();
    chk("ae_rlevel", rlevel, 2);
    chk("ae_ralmost_empty", ralmost_empty, 1);
    step(1'b1, 5'd16);
    step(1'b1, 5'd16);
    // drive rbin to 31, then wrap with wptr=1
    step(1'b0, 5'd31);
    for (int i = 0; i < 15; i++) step(1'b1, 5'd31);
    step(1'b0, 5'd1);
    settle();
    chk("pre_wrap_gray", rptr_gray, 5'b10000);
    chk("pre_wrap_rlevel", rlevel, 2);
    step(1'b1, 5'd1);
    settle();
    chk("wrap_raddr", raddr, 0);
    chk("wrap_gray", rptr_gray, 5'b00000);
    chk("wrap_rlevel", rlevel, 1);
    step(1'b1, 5'd1);
    // underflow then valid pops
    step(1'b1, 5'd1);
    step(1'b0, 5'd3);
    step(1'b1, 5'd3);
    step(1'b0, 5'd3);
    settle();
`ifdef RPTR_UNDERFLOW_ERR_EN
    chk("sticky_rerr", rerr, 1);
`else
    chk("sticky_rerr", rerr, 0);
`endif
    // asynchronous reset with level 5
    step(1'b0, 5'd7);
    settle();
    chk("pre_reset_rlevel", rlevel, 5);
    @(negedge rclk); #2 rrst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    model_reset();
    #1 chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
